// File: rtl/udp_gen_pkg.sv
// Shared types for the UDP frame generator scheduler: field widths,
// flow descriptor layout and scheduler FSM state encoding.
package udp_gen_pkg;

  localparam int unsigned MAC_W  = 48;
  localparam int unsigned IP_W   = 32;
  localparam int unsigned PORT_W = 16;

  typedef struct packed {
    logic [MAC_W-1:0]  dst_mac;
    logic [IP_W-1:0]   src_ip;
    logic [IP_W-1:0]   dst_ip;
    logic [PORT_W-1:0] src_port;
    logic [PORT_W-1:0] dst_port;
  } flow_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_RUN    = 2'd2,
    ST_GAP    = 2'd3
  } sched_state_t;

endpackage

// File: rtl/udp_rr_arb.sv
// Combinational round-robin arbiter: grants the first enabled flow strictly
// after ptr_i in circular order; valid_o is low when the mask is empty.
module udp_rr_arb #(
  parameter int unsigned FLOW_NR = 4
) (
  input  logic [FLOW_NR-1:0]         mask_i,
  input  logic [$clog2(FLOW_NR)-1:0] ptr_i,
  output logic [$clog2(FLOW_NR)-1:0] grant_o,
  output logic                       valid_o
);

  localparam int unsigned PW = $clog2(FLOW_NR);

  logic [PW-1:0] idx;

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= FLOW_NR; i++) begin
      idx = PW'((32'(ptr_i) + i) % FLOW_NR);
      if (!valid_o && mask_i[idx]) begin
        valid_o = 1'b1;
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/udp_flow_sched.sv
// Round-robin flow scheduler for the UDP frame generator: one frame per
// grant, fixed inter-frame gap, frame limit, graceful stop and watchdog.
module udp_flow_sched
  import udp_gen_pkg::*;
#(
  parameter int unsigned FLOW_NR        = 4,
  parameter int unsigned GAP_CYCLES     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                       clk_i,
  input  logic                       a_rst_n_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic [CNT_WIDTH-1:0]       frames_i,
  input  logic [FLOW_NR-1:0]         flow_en_i,
  input  logic [FLOW_NR*48-1:0]      flow_dst_mac_i,
  input  logic [FLOW_NR*32-1:0]      flow_src_ip_i,
  input  logic [FLOW_NR*32-1:0]      flow_dst_ip_i,
  input  logic [FLOW_NR*16-1:0]      flow_src_port_i,
  input  logic [FLOW_NR*16-1:0]      flow_dst_port_i,
  input  logic                       gen_frame_end_i,
  output logic                       gen_en_o,
  output logic [47:0]                gen_dst_mac_o,
  output logic [31:0]                gen_src_ip_o,
  output logic [31:0]                gen_dst_ip_o,
  output logic [15:0]                gen_src_port_o,
  output logic [15:0]                gen_dst_port_o,
  output logic [$clog2(FLOW_NR)-1:0] cur_flow_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [CNT_WIDTH-1:0]       frame_cnt_o,
  output logic                       err_o
);

  localparam int unsigned PW    = $clog2(FLOW_NR);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  // Reset asserts asynchronously and releases two edges after a_rst_n_i rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) rst_sync_q <= '0;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  flow_desc_t desc_arr [FLOW_NR];

  for (genvar k = 0; k < FLOW_NR; k++) begin : g_unpack
    assign desc_arr[k] = '{
      dst_mac:  flow_dst_mac_i [k*MAC_W  +: MAC_W],
      src_ip:   flow_src_ip_i  [k*IP_W   +: IP_W],
      dst_ip:   flow_dst_ip_i  [k*IP_W   +: IP_W],
      src_port: flow_src_port_i[k*PORT_W +: PORT_W],
      dst_port: flow_dst_port_i[k*PORT_W +: PORT_W]
    };
  end

  sched_state_t         state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        cur_flow_q, cur_flow_d;
  logic [CNT_WIDTH-1:0] limit_q, limit_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 err_q, err_d;
  logic                 stop_q, stop_d;
  logic                 gen_en_q, gen_en_d;
  logic                 done_q, done_d;
  flow_desc_t           desc_q, desc_d;

  logic [PW-1:0] arb_grant;
  logic          arb_valid;
  logic          limit_hit;

  udp_rr_arb #(.FLOW_NR(FLOW_NR)) u_arb (
    .mask_i  (flow_en_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .valid_o (arb_valid)
  );

  assign limit_hit = (limit_q != '0) && (cnt_q == limit_q);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cur_flow_d = cur_flow_q;
    limit_d    = limit_q;
    cnt_d      = cnt_q;
    wd_d       = wd_q;
    gap_d      = gap_q;
    err_d      = err_q;
    gen_en_d   = gen_en_q;
    desc_d     = desc_q;
    done_d     = 1'b0;
    stop_d     = (state_q == ST_IDLE) ? 1'b0 : (stop_q | stop_i);

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          limit_d = frames_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (!arb_valid) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          desc_d     = desc_arr[arb_grant];
          cur_flow_d = arb_grant;
          rr_ptr_d   = arb_grant;
          gen_en_d   = 1'b1;
          wd_d       = '0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        // Dropping enable on the frame_end edge keeps the generator from relaunching.
        if (gen_frame_end_i) begin
          gen_en_d = 1'b0;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          gap_d    = '0;
          state_d  = ST_GAP;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          gen_en_d = 1'b0;
          err_d    = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          if (stop_q || stop_i || limit_hit) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SELECT;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= PW'(FLOW_NR - 1);
      cur_flow_q <= '0;
      limit_q    <= '0;
      cnt_q      <= '0;
      wd_q       <= '0;
      gap_q      <= '0;
      err_q      <= 1'b0;
      stop_q     <= 1'b0;
      gen_en_q   <= 1'b0;
      done_q     <= 1'b0;
      desc_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cur_flow_q <= cur_flow_d;
      limit_q    <= limit_d;
      cnt_q      <= cnt_d;
      wd_q       <= wd_d;
      gap_q      <= gap_d;
      err_q      <= err_d;
      stop_q     <= stop_d;
      gen_en_q   <= gen_en_d;
      done_q     <= done_d;
      desc_q     <= desc_d;
    end
  end

  assign gen_en_o       = gen_en_q;
  assign gen_dst_mac_o  = desc_q.dst_mac;
  assign gen_src_ip_o   = desc_q.src_ip;
  assign gen_dst_ip_o   = desc_q.dst_ip;
  assign gen_src_port_o = desc_q.src_port;
  assign gen_dst_port_o = desc_q.dst_port;
  assign cur_flow_o     = cur_flow_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = done_q;
  assign frame_cnt_o    = cnt_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_udp_flow_sched.sv
// Bench for udp_flow_sched: generator model, frame-level reference model of
// grant order / window lengths / gaps, and directed + randomized runs.
module tb_udp_flow_sched;

  localparam int unsigned N    = 4;
  localparam int unsigned GAP  = 12;
  localparam int unsigned TMO  = 256;
  localparam int unsigned CW   = 32;
  localparam int unsigned FLEN = 86;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            a_rst_n = 1'b0;
  logic            start_i = 1'b0;
  logic            stop_i  = 1'b0;
  logic [CW-1:0]   frames_i = '0;
  logic [N-1:0]    flow_en_i = '0;
  logic [N*48-1:0] flow_dst_mac;
  logic [N*32-1:0] flow_src_ip;
  logic [N*32-1:0] flow_dst_ip;
  logic [N*16-1:0] flow_src_port;
  logic [N*16-1:0] flow_dst_port;
  logic            gen_frame_end;
  logic            gen_en_o;
  logic [47:0]     gen_dst_mac_o;
  logic [31:0]     gen_src_ip_o;
  logic [31:0]     gen_dst_ip_o;
  logic [15:0]     gen_src_port_o;
  logic [15:0]     gen_dst_port_o;
  logic [1:0]      cur_flow_o;
  logic            busy_o;
  logic            done_o;
  logic [CW-1:0]   frame_cnt_o;
  logic            err_o;

  udp_flow_sched #(
    .FLOW_NR(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .a_rst_n_i(a_rst_n), .start_i(start_i), .stop_i(stop_i),
    .frames_i(frames_i), .flow_en_i(flow_en_i),
    .flow_dst_mac_i(flow_dst_mac), .flow_src_ip_i(flow_src_ip),
    .flow_dst_ip_i(flow_dst_ip), .flow_src_port_i(flow_src_port),
    .flow_dst_port_i(flow_dst_port), .gen_frame_end_i(gen_frame_end),
    .gen_en_o(gen_en_o), .gen_dst_mac_o(gen_dst_mac_o),
    .gen_src_ip_o(gen_src_ip_o), .gen_dst_ip_o(gen_dst_ip_o),
    .gen_src_port_o(gen_src_port_o), .gen_dst_port_o(gen_dst_port_o),
    .cur_flow_o(cur_flow_o), .busy_o(busy_o), .done_o(done_o),
    .frame_cnt_o(frame_cnt_o), .err_o(err_o)
  );

  // Generator model: frame_end on the 86th consecutive enabled cycle.
  bit       respond = 1'b1;
  logic [8:0] beat_q = '0;
  always @(posedge clk) beat_q <= gen_en_o ? beat_q + 1'b1 : '0;
  assign gen_frame_end = respond && gen_en_o && (beat_q == 9'(FLEN - 1));

  logic [47:0] f_mac   [N];
  logic [31:0] f_sip   [N];
  logic [31:0] f_dip   [N];
  logic [15:0] f_sport [N];
  logic [15:0] f_dport [N];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_flow(input logic [N-1:0] m, input int p);
    for (int i = 1; i <= int'(N); i++) begin
      int j;
      j = (p + i) % int'(N);
      if (m[j]) return j;
    end
    return p;
  endfunction

  // Frame-level monitor / reference model, sampled on the falling edge.
  int  m_ptr = N - 1;
  int  exp_flow = 0;
  int  wins = 0;
  int  hi_len = 0;
  int  lo_len = 0;
  int  done_cnt = 0;
  bit  had_fall = 0;
  bit  prev_en = 0;
  bit  prev_fe = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!a_rst_n) begin
        m_ptr = N - 1; hi_len = 0; lo_len = 0;
        had_fall = 0; prev_en = 0; prev_fe = 0;
      end else begin
        if (prev_fe) check("en_low_after_fe", 64'(gen_en_o), 64'd0);
        prev_fe = gen_frame_end;
        if (gen_en_o) begin
          if (!prev_en) begin
            if (had_fall) check("gap_len", 64'(lo_len), 64'(GAP + 1));
            m_ptr    = next_flow(flow_en_i, m_ptr);
            exp_flow = m_ptr;
            wins++;
            hi_len = 0;
          end
          hi_len++;
          check("cur_flow", 64'(cur_flow_o), 64'(exp_flow));
          check("dst_mac",  64'(gen_dst_mac_o),  64'(f_mac[exp_flow]));
          check("src_ip",   64'(gen_src_ip_o),   64'(f_sip[exp_flow]));
          check("dst_ip",   64'(gen_dst_ip_o),   64'(f_dip[exp_flow]));
          check("src_port", 64'(gen_src_port_o), 64'(f_sport[exp_flow]));
          check("dst_port", 64'(gen_dst_port_o), 64'(f_dport[exp_flow]));
        end else begin
          if (prev_en) begin
            check("win_len", 64'(hi_len), respond ? 64'(FLEN) : 64'(TMO));
            had_fall = 1;
            lo_len = 0;
          end
          lo_len++;
        end
        if (done_o) begin
          done_cnt++;
          if (had_fall && !err_o) check("done_gap", 64'(lo_len), 64'(GAP + 1));
          had_fall = 0;
        end
        prev_en = gen_en_o;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_run(input logic [N-1:0] mask, input int frames);
    @(negedge clk);
    flow_en_i = mask;
    frames_i  = CW'(frames);
    start_i   = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    #1;
  endtask

  task automatic wait_done(input int d0, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done_cnt != d0) seen = 1;
    end
    check("done_seen", 64'(seen), 64'd1);
    repeat (3) tick();
    check("done_once", 64'(done_cnt), 64'(d0 + 1));
    check("idle_busy", 64'(busy_o), 64'd0);
  endtask

  task automatic wait_window(input int w, input int len, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (wins == w && hi_len == len) seen = 1;
    end
    check("window_reached", 64'(seen), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    int d0, w0, f;
    logic [N-1:0] m;

    for (int k = 0; k < int'(N); k++) begin
      f_mac[k]   = {16'($urandom), 32'($urandom)};
      f_sip[k]   = 32'($urandom);
      f_dip[k]   = 32'($urandom);
      f_sport[k] = 16'($urandom);
      f_dport[k] = 16'($urandom);
      flow_dst_mac [k*48 +: 48] = f_mac[k];
      flow_src_ip  [k*32 +: 32] = f_sip[k];
      flow_dst_ip  [k*32 +: 32] = f_dip[k];
      flow_src_port[k*16 +: 16] = f_sport[k];
      flow_dst_port[k*16 +: 16] = f_dport[k];
    end

    repeat (3) tick();
    check("rst_gen_en",  64'(gen_en_o), 64'd0);
    check("rst_busy",    64'(busy_o), 64'd0);
    check("rst_done",    64'(done_o), 64'd0);
    check("rst_cnt",     64'(frame_cnt_o), 64'd0);
    check("rst_err",     64'(err_o), 64'd0);
    check("rst_cur",     64'(cur_flow_o), 64'd0);
    check("rst_dst_mac", 64'(gen_dst_mac_o), 64'd0);
    a_rst_n = 1'b1;
    repeat (5) tick();

    // Frame limit with sparse mask: grants 0,1,3,0,1,3.
    d0 = done_cnt; w0 = wins;
    start_run(4'b1011, 6);
    check("start_busy", 64'(busy_o), 64'd1);
    wait_done(d0, 2000);
    check("lim_cnt",  64'(frame_cnt_o), 64'd6);
    check("lim_wins", 64'(wins), 64'(w0 + 6));
    check("lim_last_flow", 64'(cur_flow_o), 64'd3);

    // Reset at cycle 40 of the second frame.
    w0 = wins;
    start_run(4'b1011, 0);
    wait_window(w0 + 2, 40, 400);
    a_rst_n = 1'b0;
    #1;
    check("mid_rst_gen_en", 64'(gen_en_o), 64'd0);
    check("mid_rst_busy",   64'(busy_o), 64'd0);
    check("mid_rst_cnt",    64'(frame_cnt_o), 64'd0);
    repeat (3) tick();
    a_rst_n = 1'b1;
    repeat (5) tick();
    d0 = done_cnt; w0 = wins;
    start_run(4'b1011, 1);
    wait_done(d0, 400);
    check("post_rst_flow", 64'(cur_flow_o), 64'd0);
    check("post_rst_cnt",  64'(frame_cnt_o), 64'd1);

    // Randomized mask and frame limit.
    for (int r = 0; r < 3; r++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      f = int'($urandom_range(1, 4));
      d0 = done_cnt; w0 = wins;
      start_run(m, f);
      wait_done(d0, 2000);
      check("rnd_cnt",  64'(frame_cnt_o), 64'(f));
      check("rnd_wins", 64'(wins), 64'(w0 + f));
    end

    // Unlimited run on a single flow, graceful stop in the third frame.
    d0 = done_cnt; w0 = wins;
    start_run(4'b0100, 0);
    wait_window(w0 + 3, 30, 1000);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    wait_done(d0, 400);
    check("stop_cnt",  64'(frame_cnt_o), 64'd3);
    check("stop_wins", 64'(wins), 64'(w0 + 3));
    check("stop_flow", 64'(cur_flow_o), 64'd2);

    // Hung generator: watchdog abort.
    respond = 1'b0;
    d0 = done_cnt; w0 = wins;
    start_run(4'b0001, 1);
    wait_done(d0, 600);
    check("wd_err",  64'(err_o), 64'd1);
    check("wd_cnt",  64'(frame_cnt_o), 64'd0);
    check("wd_wins", 64'(wins), 64'(w0 + 1));
    respond = 1'b1;
    d0 = done_cnt;
    start_run(4'b0001, 1);
    check("err_cleared", 64'(err_o), 64'd0);
    wait_done(d0, 400);
    check("wd_recover_cnt", 64'(frame_cnt_o), 64'd1);
    check("wd_recover_err", 64'(err_o), 64'd0);

    // Empty mask: SELECT then straight back to IDLE.
    d0 = done_cnt; w0 = wins;
    start_run(4'b0000, 3);
    check("empty_select_busy", 64'(busy_o), 64'd1);
    check("empty_done_early",  64'(done_o), 64'd0);
    tick();
    check("empty_done",  64'(done_o), 64'd1);
    check("empty_busy",  64'(busy_o), 64'd0);
    repeat (4) tick();
    check("empty_no_win", 64'(wins), 64'(w0));
    check("empty_done_once", 64'(done_cnt), 64'(d0 + 1));
    check("empty_gen_en", 64'(gen_en_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/udp_flow_sched.md
Name: udp_flow_sched

Overview:
Scheduler and controller for the 64-bit UDP frame generator. It holds up to FLOW_NR flow descriptors (dst MAC, src/dst IPv4, src/dst UDP port) and selects enabled flows round-robin. It drives the generator's enable and address inputs for exactly one frame per grant and inserts a programmable inter-frame gap. It counts frames, supports a frame limit and graceful stop, and guards against a hung generator with a watchdog.

Parameters:
FLOW_NR, 4, number of flow descriptors (2..16)
GAP_CYCLES, 12, idle cycles with gen_en_o low between frames (>=1)
TIMEOUT_CYCLES, 256, max cycles from launch to gen_frame_end_i before abort
CNT_WIDTH, 32, width of frame limit and frame counter

Ports:
clk_i  in  1  clock
a_rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  pulse; begins a run from IDLE, ignored otherwise
stop_i  in  1  pulse; graceful stop after the current frame
frames_i  in  CNT_WIDTH  frames per run, sampled at start; 0 = unlimited
flow_en_i  in  FLOW_NR  per-flow enable mask, sampled in SELECT
flow_dst_mac_i  in  FLOW_NR*48  flattened, flow k at [k*48 +: 48]
flow_src_ip_i  in  FLOW_NR*32  flattened
flow_dst_ip_i  in  FLOW_NR*32  flattened
flow_src_port_i  in  FLOW_NR*16  flattened
flow_dst_port_i  in  FLOW_NR*16  flattened
gen_frame_end_i  in  1  generator frame_end (1-cycle pulse on last beat)
gen_en_o  out  1  generator enable, registered
gen_dst_mac_o  out  48  registered descriptor to generator
gen_src_ip_o  out  32  "
gen_dst_ip_o  out  32  "
gen_src_port_o  out  16  "
gen_dst_port_o  out  16  "
cur_flow_o  out  $clog2(FLOW_NR)  index of the granted flow
busy_o  out  1  high in any state except IDLE
done_o  out  1  1-cycle pulse on return to IDLE after a run
frame_cnt_o  out  CNT_WIDTH  frames completed this run; cleared at start
err_o  out  1  sticky watchdog error; cleared by start_i

Behaviour:
- Reset (async assert, sync deassert handled at top): all outputs 0, state IDLE, RR pointer = FLOW_NR-1, so flow 0 is granted first.
- All outputs registered. Descriptor outputs load only in SELECT and stay stable through RUN and GAP.
- FSM states: IDLE, SELECT, RUN, GAP.
- IDLE:
  - start_i: latch frames_i, clear frame_cnt_o and err_o, go to SELECT.
- SELECT (1 cycle):
  - If flow_en_i == 0: go to IDLE and pulse done_o.
  - Otherwise grant the first set bit strictly after the RR pointer, in circular order.
  - Load descriptor and cur_flow_o, update the RR pointer, set gen_en_o <= 1, go to RUN.
- RUN:
  - gen_en_o held 1. Watchdog counts from 0.
  - On gen_frame_end_i sampled high: gen_en_o <= 0 at that same edge, frame_cnt_o += 1, go to GAP. This keeps the generator from restarting from its idle state.
  - If the watchdog reaches TIMEOUT_CYCLES-1 without frame_end: gen_en_o <= 0, err_o <= 1, go to IDLE, pulse done_o. frame_cnt_o is not incremented.
- GAP:
  - gen_en_o = 0 for exactly GAP_CYCLES cycles.
  - Then go to IDLE with a done_o pulse if (stop pending) or (limit != 0 and frame_cnt_o == limit). Otherwise go to SELECT.
- stop_i:
  - Sets a stop-pending flag in SELECT, RUN or GAP. A frame in flight always completes.
  - In IDLE, stop_i is ignored.
  - The flag clears on entry to IDLE.
  - stop_i and start_i together in IDLE: start wins; stop is ignored.
- Frame counter saturates at all-ones; it does not wrap.
- A mask change during RUN or GAP takes effect at the next SELECT.
- A disabled current flow is skipped.
- A single enabled flow is granted repeatedly.
- Frame length is 86 beats (header 5, payload 81), so launch to frame_end is 86 cycles.

Decomposition:
- Package udp_gen_pkg holds:
  - MAC/IPv4/port width localparams
  - the flow descriptor packed struct
  - the sched_state_t enum
- One sub-module, udp_rr_arb: combinational round-robin next-grant from mask and pointer, parameterised by FLOW_NR.

Test Plan:
- Reset mid-RUN (assert a_rst_n_i at cycle 40 of a frame) -> gen_en_o, busy_o, frame_cnt_o go to 0 immediately; next start grants flow 0.
- flow_en_i=4'b1011, frames_i=6, start -> grant order 0,1,3,0,1,3; 6 gen_en_o high windows of 86 cycles; gaps of 12 cycles; done_o once; frame_cnt_o=6.
- frames_i=0, flow_en_i=4'b0100, stop_i pulsed at cycle 30 of the third frame -> third frame completes, then 12-cycle gap, then IDLE; frame_cnt_o=3; cur_flow_o=2 throughout.
- Generator model never returns frame_end -> gen_en_o drops after 256 cycles; err_o=1; done_o pulse; frame_cnt_o=0; the next start clears err_o.
- flow_en_i=0 at start -> SELECT then IDLE; done_o asserts 2 cycles after start; gen_en_o never rises.
- Check gen_en_o is low in the cycle after every gen_frame_end_i pulse, and descriptor outputs match flow k's slices for the whole RUN window.
